// File: rtl/writeback_stage.sv
// Final pipeline stage: formats load data, picks the result source and merges
// divider results into the single register-file write port via a 1-entry buffer.
module writeback_stage #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic            mem_reg_wr,
    input  logic [4:0]      mem_rd,
    input  logic [1:0]      mem_wb_sel,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_load_data,
    input  logic [XLEN-1:0] mem_pc_plus4,
    output logic            wb_stall,
    input  logic            div_valid,
    input  logic [4:0]      div_rd,
    input  logic [XLEN-1:0] div_result,
    output logic            div_ready,
    output logic            wr_en,
    output logic [4:0]      wr_addr,
    output logic [XLEN-1:0] wr_data
);

    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT - 1);

    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            buf_valid_q, buf_valid_d;
    logic [4:0]      buf_rd_q, buf_rd_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic [CW-1:0]   starve_q, starve_d;

    logic [1:0]      off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;
    logic [XLEN-1:0] p_data;
    logic            p_wr;
    logic            div_acc;
    logic            div_live;

    always_comb begin
        off     = mem_alu_result[1:0];
        ld_byte = mem_load_data[8*off +: 8];
        ld_half = off[1] ? mem_load_data[31:16] : mem_load_data[15:0];
        ld_fmt  = mem_load_data;
        case (mem_funct3)
            3'd0:    ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'd1:    ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'd4:    ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
            3'd5:    ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_fmt = mem_load_data;
        endcase
    end

    always_comb begin
        case (mem_wb_sel)
            2'd1:    p_data = ld_fmt;
            2'd2:    p_data = mem_pc_plus4;
            default: p_data = mem_alu_result;
        endcase
    end

    // Stall only to let a starved buffered divider result drain.
    assign wb_stall  = buf_valid_q && (starve_q >= STARVE_MAX);
    assign div_ready = !buf_valid_q;
    assign div_acc   = div_valid && div_ready;
    assign div_live  = div_acc && (div_rd != 5'd0);
    assign p_wr      = mem_valid && mem_reg_wr && (mem_rd != 5'd0) && !wb_stall;

    always_comb begin
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        if (p_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = mem_rd;
            wr_data_d = p_data;
            // Pipeline result is younger; an older divider value to the same rd dies.
            if (buf_valid_q && buf_rd_q == mem_rd) begin
                buf_valid_d = 1'b0;
            end else if (div_live && div_rd != mem_rd) begin
                buf_valid_d = 1'b1;
                buf_rd_d    = div_rd;
                buf_data_d  = div_result;
            end
        end else if (buf_valid_q) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = buf_rd_q;
            wr_data_d   = buf_data_q;
            buf_valid_d = 1'b0;
        end else if (div_live) begin
            wr_en_d   = 1'b1;
            wr_addr_d = div_rd;
            wr_data_d = div_result;
        end
    end

    always_comb begin
        starve_d = '0;
        if (buf_valid_q && buf_valid_d && starve_q != {CW{1'b1}}) begin
            starve_d = starve_q + 1'b1;
        end else if (buf_valid_q && buf_valid_d) begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_rd_q    <= '0;
            buf_data_q  <= '0;
            starve_q    <= '0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            buf_valid_q <= buf_valid_d;
            buf_rd_q    <= buf_rd_d;
            buf_data_q  <= buf_data_d;
            starve_q    <= starve_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
